// File: rtl/vga_mon_pkg.sv
// vga_mon_pkg: shared constants and types for the VGA frame monitor.
//   - 640x480@60 timing defaults (used as parameter defaults of the top)
//   - TinyVGA PMOD bit positions and the idle (syncs high) byte
//   - monitor state enum
//   - CRC-16/CCITT polynomial and seed, plus helpers
package vga_mon_pkg;

    localparam int H_TOTAL_DEF     = 800;
    localparam int V_TOTAL_DEF     = 525;
    localparam int H_ACT_START_DEF = 144;
    localparam int H_ACTIVE_DEF    = 640;
    localparam int V_ACT_START_DEF = 35;
    localparam int V_ACTIVE_DEF    = 480;

    localparam int PMOD_R1 = 0;
    localparam int PMOD_G1 = 1;
    localparam int PMOD_B1 = 2;
    localparam int PMOD_VS = 3;
    localparam int PMOD_R0 = 4;
    localparam int PMOD_G0 = 5;
    localparam int PMOD_B0 = 6;
    localparam int PMOD_HS = 7;

    localparam logic [7:0] PMOD_IDLE = 8'h88;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } mon_state_e;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // 10-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (&v) ? v : v + 10'd1;
    endfunction

    // Colour bits of a PMOD byte reordered into the CRC input byte
    // {2'b00, R1, R0, G1, G0, B1, B0}.
    function automatic logic [7:0] crc_byte(input logic [7:0] pmod);
        return {2'b00, pmod[PMOD_R1], pmod[PMOD_R0], pmod[PMOD_G1],
                pmod[PMOD_G0], pmod[PMOD_B1], pmod[PMOD_B0]};
    endfunction

endpackage

// File: rtl/vga_frame_monitor_if.sv
// vga_frame_monitor_if: sample stream in, per-frame results out.
//   pix_en, vga_in     : sample strobe and PMOD byte (driven by master)
//   frame_valid        : one-clk pulse when the result fields update
//   h_total, v_total   : last line length / frame line count
//   lit_count          : lit active pixels of the last frame
//   frame_crc          : CRC of the active picture (0 when CRC not built)
//   locked             : last frame matched the expected totals
//   mismatch_err       : sticky, a mismatch was seen while locked
// Modports: master = pixel source / result consumer, slave = monitor.
interface vga_frame_monitor_if;
    logic        pix_en;
    logic [7:0]  vga_in;
    logic        frame_valid;
    logic [9:0]  h_total;
    logic [9:0]  v_total;
    logic [18:0] lit_count;
    logic [15:0] frame_crc;
    logic        locked;
    logic        mismatch_err;

    modport master (
        output pix_en, vga_in,
        input  frame_valid, h_total, v_total, lit_count, frame_crc,
               locked, mismatch_err
    );

    modport slave (
        input  pix_en, vga_in,
        output frame_valid, h_total, v_total, lit_count, frame_crc,
               locked, mismatch_err
    );
endinterface

// File: rtl/vga_mon_crc16.sv
// vga_mon_crc16: combinational one-byte CRC-16/CCITT step, MSB first,
// non-reflected.
//   crc_in  : current CRC register
//   data    : input byte
//   crc_out : CRC after shifting in all 8 bits of data
module vga_mon_crc16
    import vga_mon_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);
    logic [15:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
            else                 c = {c[14:0], 1'b0};
        end
        crc_out = c;
    end
endmodule

// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: recovers line/frame timing from a TinyVGA PMOD stream
// and publishes per-frame statistics on each VSYNC falling edge.
//   clk, rst : clock, synchronous active-high reset
//   mon      : vga_frame_monitor_if.slave (pix_en/vga_in in, results out)
// Build option: define VGA_MON_CRC_EN to build the active-picture CRC;
// otherwise frame_crc is tied to 0.
module vga_frame_monitor
    import vga_mon_pkg::*;
#(
    parameter int H_TOTAL     = H_TOTAL_DEF,
    parameter int V_TOTAL     = V_TOTAL_DEF,
    parameter int H_ACT_START = H_ACT_START_DEF,
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACT_START = V_ACT_START_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    vga_frame_monitor_if.slave    mon
);
    localparam logic [10:0] XA_LO = 11'(H_ACT_START);
    localparam logic [10:0] XA_HI = 11'(H_ACT_START + H_ACTIVE);
    localparam logic [10:0] YA_LO = 11'(V_ACT_START);
    localparam logic [10:0] YA_HI = 11'(V_ACT_START + V_ACTIVE);
    localparam logic [9:0]  H_TOTAL_L = 10'(H_TOTAL);
    localparam logic [9:0]  V_TOTAL_L = 10'(V_TOTAL);

    // Only the sync bits of the previous sample are needed for edge detect.
    logic [7:0]  s_q, s_d;
    logic        p_hs_q, p_hs_d, p_vs_q, p_vs_d;
    logic [9:0]  x_q, x_d, vcnt_q, vcnt_d, line_len_q, line_len_d;
    logic [18:0] lit_acc_q, lit_acc_d;
    mon_state_e  state_q, state_d;
    logic        fv_q, fv_d;
    logic [9:0]  h_total_q, h_total_d, v_total_q, v_total_d;
    logic [18:0] lit_count_q, lit_count_d;
    logic        mismatch_q, mismatch_d;

    logic        hs_fall, vs_fall, active, pix_lit, match;
    logic [9:0]  x_cur, vcnt_cur, line_len_cur, y_cur;

`ifdef VGA_MON_CRC_EN
    logic [15:0] crc_acc_q, crc_acc_d, crc_next;
    logic [15:0] frame_crc_q, frame_crc_d;

    vga_mon_crc16 u_crc (
        .crc_in  (crc_acc_q),
        .data    (crc_byte(s_q)),
        .crc_out (crc_next)
    );
`endif

    // Everything below describes the sample currently held in s_q.
    always_comb begin
        hs_fall      = p_hs_q & ~s_q[PMOD_HS];
        vs_fall      = p_vs_q & ~s_q[PMOD_VS];
        x_cur        = hs_fall ? 10'd0 : sat_inc10(x_q);
        vcnt_cur     = hs_fall ? sat_inc10(vcnt_q) : vcnt_q;
        line_len_cur = hs_fall ? sat_inc10(x_q) : line_len_q;
        // vcnt 0 wraps y to 1023, which is never inside the active window.
        y_cur        = vcnt_cur - 10'd1;
        active       = ({1'b0, x_cur} >= XA_LO) && ({1'b0, x_cur} < XA_HI) &&
                       ({1'b0, y_cur} >= YA_LO) && ({1'b0, y_cur} < YA_HI);
        pix_lit      = |{s_q[PMOD_B0], s_q[PMOD_G0], s_q[PMOD_R0],
                         s_q[PMOD_B1], s_q[PMOD_G1], s_q[PMOD_R1]};
        // vcnt_q excludes a coincident hs_fall, which belongs to the new frame.
        match        = (line_len_cur == H_TOTAL_L) && (vcnt_q == V_TOTAL_L);
    end

    always_comb begin
        s_d         = s_q;
        p_hs_d      = p_hs_q;
        p_vs_d      = p_vs_q;
        x_d         = x_q;
        vcnt_d      = vcnt_q;
        line_len_d  = line_len_q;
        lit_acc_d   = lit_acc_q;
        state_d     = state_q;
        fv_d        = 1'b0;
        h_total_d   = h_total_q;
        v_total_d   = v_total_q;
        lit_count_d = lit_count_q;
        mismatch_d  = mismatch_q;
`ifdef VGA_MON_CRC_EN
        crc_acc_d   = crc_acc_q;
        frame_crc_d = frame_crc_q;
`endif
        if (mon.pix_en) begin
            s_d        = mon.vga_in;
            p_hs_d     = s_q[PMOD_HS];
            p_vs_d     = s_q[PMOD_VS];
            x_d        = x_cur;
            vcnt_d     = vcnt_cur;
            line_len_d = line_len_cur;
            if (active && pix_lit) lit_acc_d = lit_acc_q + 19'd1;
`ifdef VGA_MON_CRC_EN
            if (active) crc_acc_d = crc_next;
`endif
            if (vs_fall) begin
                vcnt_d    = hs_fall ? 10'd1 : 10'd0;
                lit_acc_d = '0;
`ifdef VGA_MON_CRC_EN
                crc_acc_d = CRC_INIT;
`endif
                if (state_q != HUNT) begin
                    fv_d        = 1'b1;
                    h_total_d   = line_len_cur;
                    v_total_d   = vcnt_q;
                    lit_count_d = lit_acc_q;
`ifdef VGA_MON_CRC_EN
                    frame_crc_d = crc_acc_q;
`endif
                end
                case (state_q)
                    HUNT:    state_d = MEASURE;
                    MEASURE: if (match) state_d = LOCKED;
                    LOCKED: begin
                        if (!match) begin
                            state_d    = MEASURE;
                            mismatch_d = 1'b1;
                        end
                    end
                    default: state_d = HUNT;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q         <= PMOD_IDLE;
            p_hs_q      <= PMOD_IDLE[PMOD_HS];
            p_vs_q      <= PMOD_IDLE[PMOD_VS];
            x_q         <= '0;
            vcnt_q      <= '0;
            line_len_q  <= '0;
            lit_acc_q   <= '0;
            state_q     <= HUNT;
            fv_q        <= 1'b0;
            h_total_q   <= '0;
            v_total_q   <= '0;
            lit_count_q <= '0;
            mismatch_q  <= 1'b0;
`ifdef VGA_MON_CRC_EN
            crc_acc_q   <= CRC_INIT;
            frame_crc_q <= '0;
`endif
        end else begin
            s_q         <= s_d;
            p_hs_q      <= p_hs_d;
            p_vs_q      <= p_vs_d;
            x_q         <= x_d;
            vcnt_q      <= vcnt_d;
            line_len_q  <= line_len_d;
            lit_acc_q   <= lit_acc_d;
            state_q     <= state_d;
            fv_q        <= fv_d;
            h_total_q   <= h_total_d;
            v_total_q   <= v_total_d;
            lit_count_q <= lit_count_d;
            mismatch_q  <= mismatch_d;
`ifdef VGA_MON_CRC_EN
            crc_acc_q   <= crc_acc_d;
            frame_crc_q <= frame_crc_d;
`endif
        end
    end

    assign mon.frame_valid  = fv_q;
    assign mon.h_total      = h_total_q;
    assign mon.v_total      = v_total_q;
    assign mon.lit_count    = lit_count_q;
    assign mon.locked       = (state_q == LOCKED);
    assign mon.mismatch_err = mismatch_q;
`ifdef VGA_MON_CRC_EN
    assign mon.frame_crc    = frame_crc_q;
`else
    assign mon.frame_crc    = 16'h0000;
`endif

endmodule
